vec_mag_sq: RTL and testbench
=============================

Name: vec_mag_sq

Overview:
- Upstream feeder for the fixed-point square-root unit in the ray/vector pipeline.
- Accepts a signed 3-component vector and computes x²+y²+z² with one shared multiplier over three cycles.
- Converts the sum to the root unit's UQ8.4 12-bit operand and issues a one-cycle start.
- Holds the operand stable until the root signals completion.

Parameters:
- COMP_W, 8, component width, signed two's complement.
- COMP_FRAC, 4, fractional bits per component (Q4.4).
- OUT_W, 12, operand width presented to the root unit.
- OUT_FRAC, 4, fractional bits of the operand (UQ8.4).

Ports:
- clk  in  1  clock
- rst_  in  1  reset
- in_valid  in  1  vector available
- in_ready  out  1  block can accept a vector (IDLE only)
- vx  in  COMP_W  x component, signed
- vy  in  COMP_W  y component, signed
- vz  in  COMP_W  z component, signed
- sqrt_a  out  OUT_W  operand to root unit, UQ8.4
- sqrt_start  out  1  one-cycle start pulse to root unit
- sqrt_done  in  1  root unit finished; operand may change
- zero_bypass  out  1  one-cycle pulse: magnitude is 0, root not issued
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: rst_ is asynchronous, active-low; clock is clk.
  - State goes to IDLE. Captured components and accumulator are cleared.
  - Outputs: sqrt_a=0, sqrt_start=0, zero_bypass=0, busy=0, in_ready=1.
  - A reset mid-operation abandons the vector; no start or bypass pulse is emitted afterwards.
- Handshake: a vector is accepted on the cycle in IDLE with in_valid=1. vx/vy/vz are registered that cycle. in_ready is combinationally high only in IDLE.
- States and transitions:
  - IDLE -> MUL_X on accept; otherwise stay in IDLE.
  - MUL_X: acc = x*x. -> MUL_Y.
  - MUL_Y: acc += y*y. -> MUL_Z.
  - MUL_Z: acc += z*z. -> NORM.
  - NORM: sqrt_a <= sat(acc >> (2*COMP_FRAC-OUT_FRAC)), truncating. If that result == 0 -> BYPASS, else -> ISSUE.
  - ISSUE: sqrt_start=1 for exactly this cycle. -> WAIT.
  - WAIT: sqrt_start=0, sqrt_a held. -> IDLE when sqrt_done=1.
  - BYPASS: zero_bypass=1 for this cycle. -> IDLE.
- Arithmetic and widths:
  - Each square is unsigned 2*COMP_W bits, Q(2*COMP_W-2*COMP_FRAC).(2*COMP_FRAC).
  - acc is 2*COMP_W+2 bits, so no overflow is possible.
  - Shift right by 4 (Q.8 -> Q.4), then saturate to 2^OUT_W-1 if any higher bit is set.
  - With defaults the maximum is 3*(-128)² = 49152 raw, which gives 3072 and never saturates. The saturation logic is still required for other parameter sets.
  - The most negative component (-128 = -8.0) squares correctly to 64.0 and must not be treated as overflow.
- Latency: start pulse in the 5th cycle after the accept edge (accept, X, Y, Z, NORM, ISSUE). sqrt_a is valid from NORM onward and stable through WAIT.
- Zero bypass: the root unit never completes for a zero operand, so a zero operand is never issued. This also covers a nonzero sum that truncates to 0 (e.g., x=1 raw only: 1 -> 0).
- sqrt_done outside WAIT is ignored.
- sqrt_done in the same cycle as ISSUE is ignored; the block waits in WAIT for the next assertion.
- Back-to-back vectors: the next accept can occur in the cycle after WAIT/BYPASS exits to IDLE.
- in_valid held high while busy has no effect. The vector is not captured until IDLE.

Decomposition:
- Shared package (Types.sv):
  - MAG_STATE_T enum {IDLE, MUL_X, MUL_Y, MUL_Z, NORM, ISSUE, WAIT, BYPASS}.
  - Constants MAG_COMP_W=8, MAG_COMP_FRAC=4, SR_IN_W=12, SR_IN_FRAC=4, shared with the root unit so operand formats stay locked.
- One sub-module is natural: sat_shift_u. It is a combinational right-shift-then-saturate with generic in/out widths, reusable for other fixed-point format conversions.
- The multiplier is inferred inline.

Test Plan:
- Reset: rst_ low mid-WAIT -> sqrt_a=0, busy=0, in_ready=1 asynchronously. After release, no sqrt_start or zero_bypass is emitted.
- Vector (3.0,4.0,0.0), i.e., vx=0x30, vy=0x40, vz=0x00 -> NORM yields sqrt_a=25.0=0x190. sqrt_start pulses once, 5 cycles after accept. Return to IDLE one cycle after sqrt_done.
- Vector (-8.0,-8.0,-8.0), all 0x80 -> sqrt_a=192.0=0xC00, no saturation. Run the same vector with COMP_W=10, COMP_FRAC=4 and all components at the most negative value (-512 = -32.0) -> sqrt_a=0xFFF (saturated).
- Zero and truncation: (0,0,0) and (vx=0x01,0,0) -> zero_bypass pulse, no sqrt_start, busy low the next cycle.
- Handshake hold: sqrt_done withheld 40 cycles -> sqrt_a stable throughout. A new in_valid is not accepted (in_ready=0). sqrt_done pulsed during MUL_Y is ignored.
- Back-to-back: two vectors with in_valid held high -> the second is accepted in the first IDLE cycle after sqrt_done. Both start pulses carry the correct operands (0x190, then 0x0C0 for (2.0,2.0,2.0)).

Source files
------------

// File: rtl/vec_mag_sq_pkg.sv
// Shared types and operand-format constants for the vector magnitude feeder.
// The root unit imports the same constants so the UQ8.4 operand format stays locked.
package vec_mag_sq_pkg;

  localparam int MAG_COMP_W    = 8;
  localparam int MAG_COMP_FRAC = 4;
  localparam int SR_IN_W       = 12;
  localparam int SR_IN_FRAC    = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_X  = 3'd1,
    MUL_Y  = 3'd2,
    MUL_Z  = 3'd3,
    NORM   = 3'd4,
    ISSUE  = 3'd5,
    WAIT   = 3'd6,
    BYPASS = 3'd7
  } mag_state_t;

endpackage

// File: rtl/vec_mag_sq_sat_shift_u.sv
// Unsigned right shift followed by saturation to a narrower width.
// Reusable for any unsigned fixed-point format conversion that drops fraction bits.
module sat_shift_u #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 12,
  parameter int SHIFT = 4
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [IN_W-1:0] shifted;

  assign shifted = din >> SHIFT;

  generate
    if (IN_W > OUT_W) begin : g_sat
      // Any surviving bit above the output width means the value does not fit.
      assign dout = (|shifted[IN_W-1:OUT_W]) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end else begin : g_pad
      assign dout = OUT_W'(shifted);
    end
  endgenerate

endmodule

// File: rtl/vec_mag_sq.sv
// Computes x^2+y^2+z^2 of a signed vector with one shared multiplier and hands the
// UQ8.4 result to the square-root unit; zero operands are bypassed since the root never finishes on them.
module vec_mag_sq
  import vec_mag_sq_pkg::*;
#(
  parameter int COMP_W    = MAG_COMP_W,
  parameter int COMP_FRAC = MAG_COMP_FRAC,
  parameter int OUT_W     = SR_IN_W,
  parameter int OUT_FRAC  = SR_IN_FRAC
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COMP_W-1:0] vx,
  input  logic [COMP_W-1:0] vy,
  input  logic [COMP_W-1:0] vz,
  output logic [OUT_W-1:0]  sqrt_a,
  output logic              sqrt_start,
  input  logic              sqrt_done,
  output logic              zero_bypass,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int SQ_W  = 2 * COMP_W;
  localparam int ACC_W = 2 * COMP_W + 2;
  localparam int SHIFT = 2 * COMP_FRAC - OUT_FRAC;

  mag_state_t         state_q, state_d;
  logic [COMP_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]   sqrt_a_q, sqrt_a_d;
  logic [COMP_W-1:0]  mul_op;
  logic [SQ_W-1:0]    mul_ext;
  logic [SQ_W-1:0]    sq;
  logic [ACC_W-1:0]   sq_ext;
  logic [OUT_W-1:0]   sat_out;

  // Shared multiplier: the operand is picked by the current MUL_* state.
  always_comb begin
    mul_op = x_q;
    case (state_q)
      MUL_Y:   mul_op = y_q;
      MUL_Z:   mul_op = z_q;
      default: mul_op = x_q;
    endcase
  end

  // Sign-extended unsigned multiply keeps the low bits of the signed square exact,
  // so -2^(COMP_W-1) squares to its true positive value.
  assign mul_ext = {{COMP_W{mul_op[COMP_W-1]}}, mul_op};
  assign sq      = mul_ext * mul_ext;
  assign sq_ext  = {2'b00, sq};

  sat_shift_u #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (acc_q),
    .dout (sat_out)
  );

  // Handshake: a vector transfers on any clock edge where in_valid && in_ready;
  // in_ready is high only in IDLE, and sqrt_done counts only while in WAIT.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    acc_d    = acc_q;
    sqrt_a_d = sqrt_a_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = vx;
          y_d     = vy;
          z_d     = vz;
          state_d = MUL_X;
        end
      end
      MUL_X: begin
        acc_d   = sq_ext;
        state_d = MUL_Y;
      end
      MUL_Y: begin
        acc_d   = acc_q + sq_ext;
        state_d = MUL_Z;
      end
      MUL_Z: begin
        acc_d   = acc_q + sq_ext;
        state_d = NORM;
      end
      NORM: begin
        sqrt_a_d = sat_out;
        state_d  = (sat_out == '0) ? BYPASS : ISSUE;
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (sqrt_done) state_d = IDLE;
      BYPASS:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      acc_q    <= '0;
      sqrt_a_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      acc_q    <= acc_d;
      sqrt_a_q <= sqrt_a_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign sqrt_start  = (state_q == ISSUE);
  assign zero_bypass = (state_q == BYPASS);
  assign sqrt_a      = sqrt_a_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vec_mag_sq.sv
// Randomised and directed bench for vec_mag_sq with a scoreboard fed by the driver
// and drained by a monitor; a small root-unit responder closes the sqrt handshake.
module tb_vec_mag_sq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default-width DUT ----------------
  logic        in_valid, in_ready;
  logic [7:0]  vx, vy, vz;
  logic [11:0] sqrt_a;
  logic        sqrt_start, sqrt_done, zero_bypass, busy;
  logic [2:0]  dbg_state;
  logic        done_resp, done_glitch;

  assign sqrt_done = done_resp | done_glitch;

  vec_mag_sq dut (
    .clk         (clk),
    .rst_        (rst_),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .vx          (vx),
    .vy          (vy),
    .vz          (vz),
    .sqrt_a      (sqrt_a),
    .sqrt_start  (sqrt_start),
    .sqrt_done   (sqrt_done),
    .zero_bypass (zero_bypass),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- 10-bit component DUT (saturation case) ----------------
  logic        w_valid, w_in_ready;
  logic [9:0]  w_vx, w_vy, w_vz;
  logic [11:0] w_sqrt_a;
  logic        w_start, w_done, w_bypass, w_busy;
  logic [2:0]  w_dbg;

  vec_mag_sq #(
    .COMP_W    (10),
    .COMP_FRAC (4),
    .OUT_W     (12),
    .OUT_FRAC  (4)
  ) dut_w (
    .clk         (clk),
    .rst_        (rst_),
    .in_valid    (w_valid),
    .in_ready    (w_in_ready),
    .vx          (w_vx),
    .vy          (w_vy),
    .vz          (w_vz),
    .sqrt_a      (w_sqrt_a),
    .sqrt_start  (w_start),
    .sqrt_done   (w_done),
    .zero_bypass (w_bypass),
    .busy        (w_busy),
    .dbg_state   (w_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [12:0] exp_q[$];   // {expect_bypass, expected operand}
  int          cyc_q[$];   // cycle count at which the pulse is due
  int          n_cmp = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          done_delay = 2;
  logic        issue_glitch = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Reference: sum of true squares in Q.8, drop 4 fraction bits, clamp to 12 bits.
  function automatic int mag_model(input int x, input int y, input int z);
    int sum;
    int q;
    sum = x * x + y * y + z * z;
    q   = sum / 16;
    return (q > 4095) ? 4095 : q;
  endfunction

  function automatic logic [12:0] exp_entry(input logic [7:0] x, input logic [7:0] y,
                                            input logic [7:0] z);
    int q;
    q = mag_model(int'($signed(x)), int'($signed(y)), int'($signed(z)));
    return {(q == 0), 12'(q)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_vec(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    @(negedge clk);
    in_valid = 1'b1;
    vx = x;
    vy = y;
    vz = z;
    for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      timeout_fail("accept");
    end else begin
      acc_cyc = cyc;
      exp_q.push_back(exp_entry(x, y, z));
      cyc_q.push_back(cyc + 5);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    if (exp_q.size() != 0 || busy) timeout_fail("drain");
  endtask

  task automatic run_wide(input logic [9:0] x, input logic [9:0] y, input logic [9:0] z);
    int q;
    q = mag_model(int'($signed(x)), int'($signed(y)), int'($signed(z)));
    @(negedge clk);
    check("wide_ready", 32'(w_in_ready), 1);
    w_valid = 1'b1;
    w_vx = x;
    w_vy = y;
    w_vz = z;
    @(negedge clk);
    w_valid = 1'b0;
    for (int i = 0; i < 20 && !(w_start || w_bypass); i++) @(negedge clk);
    if (!(w_start || w_bypass)) begin
      timeout_fail("wide_pulse");
    end else begin
      check("wide_operand", 32'({w_bypass, w_sqrt_a}), 32'({(q == 0), 12'(q)}));
      if (w_start) begin
        @(negedge clk);
        w_done = 1'b1;
        @(negedge clk);
        w_done = 1'b0;
      end
      @(negedge clk);
      check("wide_idle", 32'(w_busy), 0);
    end
  endtask

  // ---------------- monitor ----------------
  logic [12:0] mon_e;
  int          mon_t;
  logic        chk_idle_next = 1'b0;

  always @(negedge clk) begin
    if (!rst_) begin
      chk_idle_next = 1'b0;
    end else begin
      if (chk_idle_next) begin
        check("bypass_then_idle", 32'(busy), 0);
        chk_idle_next = 1'b0;
      end
      if (sqrt_start || zero_bypass) begin
        pulse_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_pulse: start=%0b bypass=%0b a=0x%0h, nothing expected (t=%0t)",
                   sqrt_start, zero_bypass, sqrt_a, $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = cyc_q.pop_front();
          check("operand", 32'({zero_bypass, sqrt_a}), 32'(mon_e));
          check("latency", cyc, mon_t);
          if (zero_bypass) chk_idle_next = 1'b1;
        end
      end
    end
  end

  // ---------------- root-unit responder ----------------
  logic [11:0] held_a;
  logic        aborted;
  int          resp_d;

  initial begin
    done_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_ && sqrt_start) begin
        held_a  = sqrt_a;
        aborted = 1'b0;
        resp_d  = done_delay;
        if (issue_glitch) done_resp = 1'b1;
        for (int i = 0; i < resp_d; i++) begin
          @(negedge clk);
          done_resp = 1'b0;
          if (!rst_) begin
            aborted = 1'b1;
            break;
          end
          check("hold_a", 32'(sqrt_a), 32'(held_a));
          check("wait_busy", 32'({busy, in_ready, sqrt_start}), 32'(3'b100));
        end
        if (!aborted) begin
          done_resp = 1'b1;
          done_cyc  = cyc;
          @(negedge clk);
          done_resp = 1'b0;
          if (rst_) check("idle_after_done", 32'({busy, in_ready}), 32'(2'b01));
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  int pulses_before;
  int b2b_done;

  initial begin
    rst_ = 1'b0;
    in_valid = 1'b0;
    vx = '0; vy = '0; vz = '0;
    done_glitch = 1'b0;
    w_valid = 1'b0;
    w_vx = '0; w_vy = '0; w_vz = '0;
    w_done = 1'b0;
    #3;
    check("rst_sqrt_a", 32'(sqrt_a), 0);
    check("rst_flags", 32'({sqrt_start, zero_bypass, busy, in_ready}), 32'(4'b0001));
    check("rst_state", 32'(dbg_state), 0);
    check("rst_wide", 32'({w_busy, w_in_ready, w_sqrt_a, w_dbg}), 32'({2'b01, 12'h0, 3'd0}));
    repeat (3) @(negedge clk);
    rst_ = 1'b1;

    // Directed: 3-4-0 triangle, most negative components, zero, truncation to zero.
    send_vec(8'h30, 8'h40, 8'h00); idle_in();
    send_vec(8'h80, 8'h80, 8'h80); idle_in();
    send_vec(8'h00, 8'h00, 8'h00); idle_in();
    send_vec(8'h01, 8'h00, 8'h00); idle_in();
    wait_drain();

    // Stray sqrt_done while the multiplier is still on the y component.
    send_vec(8'h10, 8'h20, 8'hF0);
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk) done_glitch = 1'b1;
    @(negedge clk) done_glitch = 1'b0;
    wait_drain();

    // sqrt_done raised during the ISSUE cycle must not end the wait.
    issue_glitch = 1'b1;
    done_delay = 3;
    send_vec(8'hE0, 8'h11, 8'h05); idle_in();
    wait_drain();
    issue_glitch = 1'b0;

    // Long hold with in_valid kept high, then a back-to-back second vector.
    done_delay = 40;
    send_vec(8'h30, 8'h40, 8'h00);
    send_vec(8'h20, 8'h20, 8'h20);
    b2b_done = done_cyc;
    check("b2b_accept_cycle", acc_cyc, b2b_done + 1);
    idle_in();
    wait_drain();

    // Random vectors, some held back-to-back, some small enough to bypass.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] rx, ry, rz;
      done_delay = $urandom_range(1, 5);
      if ($urandom_range(0, 3) == 0) begin
        rx = 8'($urandom_range(0, 3));
        ry = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        rz = 8'($urandom_range(0, 2));
      end else begin
        rx = 8'($urandom_range(0, 255));
        ry = 8'($urandom_range(0, 255));
        rz = 8'($urandom_range(0, 255));
      end
      send_vec(rx, ry, rz);
      if ($urandom_range(0, 1) == 1) idle_in();
    end
    idle_in();
    wait_drain();

    // Asynchronous reset while waiting on the root unit.
    done_delay = 100;
    send_vec(8'h30, 8'h40, 8'h00); idle_in();
    for (int i = 0; i < 20 && !sqrt_start; i++) @(negedge clk);
    if (!sqrt_start) timeout_fail("reset_test_start");
    repeat (3) @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    check("async_rst_sqrt_a", 32'(sqrt_a), 0);
    check("async_rst_flags", 32'({busy, in_ready, sqrt_start, zero_bypass}), 32'(4'b0100));
    pulses_before = pulse_cnt;
    exp_q.delete();
    cyc_q.delete();
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    repeat (15) @(negedge clk);
    check("no_pulse_after_reset", pulse_cnt, pulses_before);
    check("idle_after_reset", 32'({busy, in_ready}), 32'(2'b01));

    // 10-bit components: most negative value saturates, a mid value does not.
    run_wide(10'h200, 10'h200, 10'h200);
    run_wide(10'd100, 10'h3CE, 10'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
